// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue buffering {pc, inst} pairs between IF and ID
// Circular buffer with registered occupancy; flush on redirect, no bypass from in_* to out_*.
module fetch_queue #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              in_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic              push;
   logic              pop;

   // Ready depends on occupancy only, so a pop never frees a slot for a same-cycle push.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_pc    = out_valid ? pc_mem[head_q]   : '0;
   assign out_inst  = out_valid ? inst_mem[head_q] : '0;
   assign count     = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (push && pop) begin
         head_d = head_q + PTR_W'(1);
         tail_d = tail_q + PTR_W'(1);
      end else if (push) begin
         tail_d  = tail_q + PTR_W'(1);
         count_d = count_q + CNT_W'(1);
      end else if (pop) begin
         head_d  = head_q + PTR_W'(1);
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is not reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         pc_mem[tail_q]   <= in_pc;
         inst_mem[tail_q] <= in_inst;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a scoreboard queue
// Inputs driven at the falling edge; outputs checked against a bench-side occupancy model.
module tb_fetch_queue;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic [ADDR_W-1:0] in_pc;
   logic [INST_W-1:0] in_inst;
   logic              in_ready;
   logic              out_valid;
   logic [ADDR_W-1:0] out_pc;
   logic [INST_W-1:0] out_inst;
   logic              out_ready;
   logic [CNT_W-1:0]  count;

   int n_assert = 0;
   int n_fail   = 0;
   logic [ADDR_W-1:0] sb_pc[$];

   fetch_queue #(
      .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
      return {pc[15:0], ~pc[15:0]} ^ 32'h0000_5A5A;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      int n;
      n = sb_pc.size();
      chk({tag, ":count"}, 64'(count), 64'(n));
      chk({tag, ":out_valid"}, 64'(out_valid), 64'(n != 0));
      chk({tag, ":in_ready"}, 64'(in_ready), 64'(n != DEPTH));
      if (n != 0) begin
         chk({tag, ":out_pc"}, 64'(out_pc), 64'(sb_pc[0]));
         chk({tag, ":out_inst"}, 64'(out_inst), 64'(inst_of(sb_pc[0])));
      end else begin
         chk({tag, ":out_pc0"}, 64'(out_pc), 64'd0);
         chk({tag, ":out_inst0"}, 64'(out_inst), 64'd0);
      end
   endtask

   // One clock: drive inputs, check current outputs, advance the model, take the edge.
   task automatic do_cycle(input string tag, input logic v, input logic [ADDR_W-1:0] pc,
                           input logic rdy, input logic fl);
      logic do_push, do_pop;
      @(negedge clk);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst_of(pc);
      out_ready = rdy;
      flush     = fl;
      #1;
      chk_outputs(tag);
      do_push = v && (sb_pc.size() != DEPTH);
      do_pop  = rdy && (sb_pc.size() != 0);
      if (fl) begin
         sb_pc.delete();
      end else begin
         if (do_pop)  void'(sb_pc.pop_front());
         if (do_push) sb_pc.push_back(pc);
      end
      @(posedge clk);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outputs("reset");
      rst = 1'b1;

      // Fill without draining, then attempt a fifth push.
      for (int i = 0; i < 4; i++) do_cycle("fill", 1'b1, 32'h1C00_0000 + 32'(4 * i), 1'b0, 1'b0);
      do_cycle("full_push", 1'b1, 32'h1C00_0010, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) do_cycle("drain", 1'b0, '0, 1'b1, 1'b0);
      do_cycle("empty_pop", 1'b0, '0, 1'b1, 1'b0);

      // Streaming across the pointer wrap.
      for (int i = 0; i < 10; i++) do_cycle("stream", 1'b1, 32'h1C00_0000 + 32'(4 * i), 1'b1, 1'b0);
      do_cycle("stream_end", 1'b0, '0, 1'b1, 1'b0);

      // Flush with a pending push; the flushed-cycle push must not be stored.
      for (int i = 0; i < 3; i++) do_cycle("pre_flush", 1'b1, 32'h1C00_0040 + 32'(4 * i), 1'b0, 1'b0);
      do_cycle("flush", 1'b1, 32'h1C00_0100, 1'b0, 1'b1);
      do_cycle("post_flush", 1'b1, 32'h1C00_0200, 1'b0, 1'b0);
      do_cycle("flush_head", 1'b0, '0, 1'b1, 1'b0);

      // Full plus same-cycle pop: the push is dropped.
      for (int i = 0; i < 4; i++) do_cycle("refill", 1'b1, 32'h1C00_0300 + 32'(4 * i), 1'b0, 1'b0);
      do_cycle("full_pop", 1'b1, 32'h1C00_0400, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) do_cycle("drain2", 1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset between edges with two entries queued.
      for (int i = 0; i < 2; i++) do_cycle("pre_rst", 1'b1, 32'h1C00_0500 + 32'(4 * i), 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      chk("pre_async:count", 64'(count), 64'd2);
      rst = 1'b0;
      #1;
      sb_pc.delete();
      chk("async_rst:count", 64'(count), 64'd0);
      chk("async_rst:out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_cycle("after_rst", 1'b1, 32'h1C00_0600, 1'b0, 1'b0);
      do_cycle("after_rst_head", 1'b1, 32'h1C00_0604, 1'b1, 1'b0);
      do_cycle("after_rst_tail", 1'b0, '0, 1'b1, 1'b0);
      do_cycle("final", 1'b0, '0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the IF stage and ID.
- Buffers {pc, inst} pairs produced by IF each cycle, so a stalled ID does not immediately back-pressure the PC register.
- Decouples IF from ID: ID stalls back-pressure IF only when the queue is full.
- Flushes on redirect (taken branch/jump, same event that drives PCSrc in IF).

Parameters:
- ADDR_W, 32, PC width (matches ADDR_BUS_WIDTH).
- INST_W, 32, instruction width.
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, 3, width of count output; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- flush  input  1  redirect; discard all entries this cycle.
- in_valid  input  1  IF presents a fetched instruction.
- in_pc  input  ADDR_W  PC of fetched instruction (PC_IF).
- in_inst  input  INST_W  instruction word read at in_pc.
- in_ready  output  1  queue can accept; IF uses it as PC_WRITE.
- out_valid  output  1  head entry valid for ID.
- out_pc  output  ADDR_W  PC of head entry.
- out_inst  output  INST_W  instruction of head entry.
- out_ready  input  1  ID consumes head this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry circular buffer of {pc, inst}.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is CNT_W bits.
- Reset (rst=0, asynchronous):
  - head=0, tail=0, count=0.
  - out_valid=0, in_ready=1, out_pc=0, out_inst=0.
  - Storage contents need no reset.
- Events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count != DEPTH), combinational from state only.
  - No pass-through when full: a same-cycle pop does not enable a push while full.
- out_valid = (count != 0).
  - out_pc/out_inst = head entry when out_valid=1, otherwise all zeros.
  - Outputs are driven from registers/storage, never combinationally from in_*.
- Latency: an entry pushed at edge N is visible on out_* after edge N; minimum one cycle IF to ID, no bypass.
- Clock-edge update, in priority order:
  1. flush=1: head=0, tail=0, count=0. Push and pop in the same cycle are ignored; the in_* data is dropped.
  2. push & pop: write at tail, tail+1, head+1, count unchanged. Only reachable when 0<count<DEPTH.
  3. push only: write at tail, tail+1, count+1.
  4. pop only: head+1, count-1.
  5. neither: hold.
- Order: strict FIFO; out_pc sequence equals the accepted in_pc sequence.
- Boundaries:
  - Pop when empty is ignored (out_valid=0).
  - Push when full is ignored (in_ready=0).
  - Pointer wrap from DEPTH-1 to 0 is transparent.
  - count never exceeds DEPTH or underflows.
- Reset asserted mid-operation clears the queue immediately, independent of clk.
  - After reset deasserts, the first push lands in entry 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> count=0, out_valid=0, in_ready=1, out_pc=0, out_inst=0.
- Fill, no drain: out_ready=0; push pc 0x1C000000, 0x1C000004, 0x1C000008, 0x1C00000C.
  - -> in_ready=0 after the 4th push, count=4.
  - A 5th push of 0x1C000010 is not accepted.
  - Draining then yields the four PCs in order.
- Streaming: in_valid=1 and out_ready=1 every cycle with PC +4 from 0x1C000000.
  - -> count settles at 1, one instruction per cycle, out_pc lags in_pc by one cycle.
  - Run 10 entries to cross pointer wrap.
- Flush: queue holds 3 entries; assert flush with in_valid=1, in_pc=0x1C000100.
  - -> next cycle count=0, out_valid=0; 0x1C000100 is not stored.
  - Next push of 0x1C000200 appears as the head.
- Full plus pop: with count=4, assert out_ready=1 and in_valid=1 in the same cycle.
  - -> count=3, the in_* entry is dropped; in_ready=1 the following cycle.
- Async reset: assert rst=0 between clock edges with count=2.
  - -> count=0 and out_valid=0 before the next rising edge.
